// File: rtl/bnn_pkg.sv
// Shared constants, reset weight image and stream FSM states for the BNN weight
// loader transmit path.
package bnn_pkg;

  localparam int NUM_NEURONS = 12;
  localparam int RX_PTR_W    = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PAD_LO,
    ST_PAD_HI,
    ST_LO,
    ST_HI,
    ST_GAP,
    ST_DONE
  } tx_state_t;

  // Power-on weights; must stay identical to the receiver's reset contents.
  function automatic logic [7:0] default_weight(input int idx);
    case (idx)
      0:       default_weight = 8'hB7;
      1:       default_weight = 8'hDB;
      2:       default_weight = 8'h07;
      3:       default_weight = 8'hD6;
      4:       default_weight = 8'hB7;
      5:       default_weight = 8'h3F;
      6:       default_weight = 8'hF6;
      7:       default_weight = 8'h6E;
      8:       default_weight = 8'h11;
      9:       default_weight = 8'h99;
      10:      default_weight = 8'h00;
      11:      default_weight = 8'h0E;
      default: default_weight = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/bnn_weight_buf.sv
// Local weight register file: synchronous write, reset to the default image,
// asynchronous read; out-of-range addresses are ignored on write and read as zero.
module bnn_weight_buf
  import bnn_pkg::*;
#(
  parameter int N = bnn_pkg::NUM_NEURONS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [3:0] wr_addr,
  input  logic [7:0] wr_data,
  input  logic [3:0] rd_addr,
  output logic [7:0] rd_data
);

  logic [7:0] mem [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) mem[i] <= default_weight(i);
    end else if (wr_en && (int'(wr_addr) < N)) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = (int'(rd_addr) < N) ? mem[rd_addr] : 8'h00;

endmodule

// File: rtl/bnn_weight_stream_tx.sv
// Serialises the local weight buffer onto the nibble/load-enable loader bus,
// padding the receiver pointer round to neuron 0 before every stream.
module bnn_weight_stream_tx
  import bnn_pkg::*;
#(
  parameter int NUM_NEURONS = bnn_pkg::NUM_NEURONS,
  parameter int RX_PTR_W    = bnn_pkg::RX_PTR_W,
  parameter int GAP_CYCLES  = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [3:0]          wr_addr,
  input  logic [7:0]          wr_data,
  input  logic                start,
  input  logic                sink_ena,
  output logic [3:0]          tx_nibble,
  output logic                tx_load_en,
  output logic                busy,
  output logic                done,
  output logic                wr_err,
  output logic [RX_PTR_W-1:0] rx_ptr
);

  tx_state_t  state;
  logic [3:0] idx;
  logic [3:0] gap_cnt;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] first_byte;
  logic       idle;
  logic       last_byte;

  assign idle      = (state == ST_IDLE);
  assign last_byte = (idx == 4'(NUM_NEURONS - 1));

  // In HI the next byte's low nibble is registered, so look one entry ahead.
  assign rd_addr = (state == ST_HI && !last_byte) ? idx + 4'd1 : idx;

  // A write landing in the same IDLE cycle as start must be seen by byte 0.
  assign first_byte = (idle && wr_en && wr_addr == 4'd0) ? wr_data : rd_data;

  bnn_weight_buf #(.N(NUM_NEURONS)) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en && idle),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      idx        <= 4'd0;
      gap_cnt    <= 4'd0;
      rx_ptr     <= '0;
      tx_nibble  <= 4'd0;
      tx_load_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      done   <= 1'b0;
      wr_err <= wr_en && !idle;
      case (state)
        ST_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            tx_load_en <= 1'b1;
            idx        <= 4'd0;
            if (rx_ptr != '0) begin
              state     <= ST_PAD_LO;
              tx_nibble <= 4'd0;
            end else begin
              state     <= ST_LO;
              tx_nibble <= first_byte[3:0];
            end
          end
        end
        ST_PAD_LO: begin
          if (sink_ena) state <= ST_PAD_HI;
        end
        ST_PAD_HI: begin
          if (sink_ena) begin
            rx_ptr <= rx_ptr + 1'b1;
            if (rx_ptr == '1) begin
              state     <= ST_LO;
              tx_nibble <= rd_data[3:0];
            end else begin
              state <= ST_PAD_LO;
            end
          end
        end
        ST_LO: begin
          if (sink_ena) begin
            state     <= ST_HI;
            tx_nibble <= rd_data[7:4];
          end
        end
        ST_HI: begin
          if (sink_ena) begin
            rx_ptr <= rx_ptr + 1'b1;
            if (last_byte) begin
              state      <= ST_DONE;
              tx_load_en <= 1'b0;
              tx_nibble  <= 4'd0;
              done       <= 1'b1;
            end else begin
              idx <= idx + 4'd1;
              if (GAP_CYCLES > 0) begin
                state      <= ST_GAP;
                tx_load_en <= 1'b0;
                tx_nibble  <= 4'd0;
                gap_cnt    <= 4'd0;
              end else begin
                state     <= ST_LO;
                tx_nibble <= rd_data[3:0];
              end
            end
          end
        end
        ST_GAP: begin
          if (sink_ena) begin
            if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
              state      <= ST_LO;
              tx_load_en <= 1'b1;
              tx_nibble  <= rd_data[3:0];
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bnn_weight_stream_tx.sv
// Self-checking bench: expected nibbles are queued at start and popped as the
// receiver model accepts them; a second instance exercises GAP_CYCLES=2.
module tb_bnn_weight_stream_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       start;
  logic       start_g;
  logic       sink_ena;

  logic [3:0] tx_nibble, g_nibble;
  logic       tx_load_en, g_load_en;
  logic       busy, g_busy;
  logic       done, g_done;
  logic       wr_err, g_wr_err;
  logic [4:0] rx_ptr, g_rx_ptr;

  bnn_weight_stream_tx dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .sink_ena(sink_ena), .tx_nibble(tx_nibble), .tx_load_en(tx_load_en),
    .busy(busy), .done(done), .wr_err(wr_err), .rx_ptr(rx_ptr)
  );

  bnn_weight_stream_tx #(.GAP_CYCLES(2)) dut_gap (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start_g), .sink_ena(sink_ena), .tx_nibble(g_nibble), .tx_load_en(g_load_en),
    .busy(g_busy), .done(g_done), .wr_err(g_wr_err), .rx_ptr(g_rx_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
    bit         applies;
  } wr_vec_t;

  logic [7:0] defaults [12] = '{8'hB7, 8'hDB, 8'h07, 8'hD6, 8'hB7, 8'h3F,
                                8'hF6, 8'h6E, 8'h11, 8'h99, 8'h00, 8'h0E};
  logic [7:0] w_model [12];
  logic [7:0] rx_mem [12];
  logic [4:0] rx_ptr_m;
  logic [3:0] rx_lo;
  bit         rx_phase;
  logic [3:0] exp_q [$];
  int         nib_cnt;
  int         vectors = 0;
  int         miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reset_models();
    for (int i = 0; i < 12; i++) begin
      w_model[i] = defaults[i];
      rx_mem[i]  = defaults[i];
    end
    rx_ptr_m = 5'd0;
    rx_phase = 1'b0;
    rx_lo    = 4'd0;
    exp_q.delete();
  endtask

  task automatic push_stream();
    if (rx_ptr_m != 5'd0)
      for (int k = int'(rx_ptr_m); k < 32; k++) begin
        exp_q.push_back(4'd0);
        exp_q.push_back(4'd0);
      end
    for (int i = 0; i < 12; i++) begin
      exp_q.push_back(w_model[i][3:0]);
      exp_q.push_back(w_model[i][7:4]);
    end
    nib_cnt = 0;
  endtask

  // Receiver model: samples on every load cycle where the sink is enabled.
  task automatic sample_rx();
    logic [3:0] nib;
    if (reset) begin
      reset_models();
      return;
    end
    if (!tx_load_en) return;
    if (!sink_ena) begin
      if (exp_q.size() > 0) check("hold_nibble", tx_nibble, exp_q[0]);
      return;
    end
    check("queue_nonempty", int'(exp_q.size() > 0), 1);
    if (exp_q.size() == 0) return;
    nib = exp_q.pop_front();
    check($sformatf("nibble_%0d", nib_cnt), tx_nibble, nib);
    nib_cnt++;
    if (!rx_phase) begin
      rx_lo    = tx_nibble;
      rx_phase = 1'b1;
    end else begin
      if (rx_ptr_m < 5'd12) rx_mem[rx_ptr_m] = {tx_nibble, rx_lo};
      rx_ptr_m = rx_ptr_m + 5'd1;
      rx_phase = 1'b0;
    end
  endtask

  task automatic check_rx_mem(input string name);
    for (int i = 0; i < 12; i++)
      check($sformatf("%s_byte%0d", name, i), rx_mem[i], w_model[i]);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    reset_models();
  endtask

  task automatic idle_write(input logic [3:0] addr, input logic [7:0] data);
    wr_en = 1'b1; wr_addr = addr; wr_data = data;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check("idle_wr_err", wr_err, 0);
  endtask

  // Drives one stream on dut and returns on done (or the cycle after a mid-stream reset).
  task automatic run_stream(input string name, input int exp_done, input int hold_at,
                            input int wr_at, input int restart_at, input int reset_at);
    int n;
    int got;
    push_stream();
    got   = -1;
    n     = 0;
    start = 1'b1;
    while (n < 300 && got < 0) begin
      @(posedge clk); #1;
      n++;
      start    = (n == restart_at);
      sink_ena = !(hold_at > 0 && n >= hold_at && n < hold_at + 3);
      wr_en    = (n == wr_at);
      wr_addr  = 4'd2;
      wr_data  = 8'h00;
      reset    = (n == reset_at);
      @(negedge clk);
      sample_rx();
      if (n == 1) check({name, "_busy"}, busy, 1);
      if (n == wr_at + 1) check({name, "_wr_err"}, wr_err, 1);
      if (reset_at > 0 && n == reset_at + 1) begin
        check({name, "_rst_load_en"}, tx_load_en, 0);
        check({name, "_rst_busy"}, busy, 0);
        check({name, "_rst_rx_ptr"}, rx_ptr, 0);
        got = n;
      end else if (done) begin
        got = n;
      end
    end
    check({name, "_done_cycle"}, got, exp_done);
    if (reset_at <= 0 && got > 0) begin
      check({name, "_load_en_at_done"}, tx_load_en, 0);
      check({name, "_queue_drained"}, exp_q.size(), 0);
      check({name, "_rx_ptr"}, rx_ptr, rx_ptr_m);
      @(posedge clk); #1;
      @(negedge clk);
      check({name, "_idle_busy"}, busy, 0);
      check({name, "_idle_done"}, done, 0);
    end
  endtask

  task automatic run_gap_stream();
    int n, got, loads, lows, first, last;
    logic [3:0] exp_nib;
    start_g = 1'b1;
    n = 0; got = -1; loads = 0; lows = 0; first = -1; last = -1;
    while (n < 300 && got < 0) begin
      @(posedge clk); #1;
      n++;
      start_g = 1'b0;
      @(negedge clk);
      if (g_load_en) begin
        if (loads < 24) begin
          exp_nib = loads[0] ? defaults[loads / 2][7:4] : defaults[loads / 2][3:0];
          check($sformatf("gap_nibble_%0d", loads), g_nibble, exp_nib);
        end
        if (first < 0) first = n;
        last = n;
        loads++;
      end else if (!g_done && first >= 0) begin
        lows++;
      end
      if (g_done) got = n;
    end
    check("gap_first_load", first, 1);
    check("gap_load_cycles", loads, 24);
    check("gap_low_cycles", lows, 22);
    check("gap_span", last - first + 1, 46);
    check("gap_done_cycle", got, 47);
    check("gap_rx_ptr", g_rx_ptr, 12);
  endtask

  initial begin
    wr_vec_t wr_tab [4];
    wr_tab[0] = '{addr: 4'd2,  data: 8'hA5, applies: 1'b1};
    wr_tab[1] = '{addr: 4'd15, data: 8'hFF, applies: 1'b0};
    wr_tab[2] = '{addr: 4'd12, data: 8'h55, applies: 1'b0};
    wr_tab[3] = '{addr: 4'd9,  data: 8'hC3, applies: 1'b1};

    reset = 1'b1; wr_en = 1'b0; wr_addr = 4'd0; wr_data = 8'd0;
    start = 1'b0; start_g = 1'b0; sink_ena = 1'b1;
    reset_models();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_nibble", tx_nibble, 0);
    check("rst_load_en", tx_load_en, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_wr_err", wr_err, 0);
    check("rst_rx_ptr", rx_ptr, 0);

    run_stream("t1", 25, -1, -1, -1, -1);
    check("t1_rx_ptr_const", rx_ptr, 12);
    check_rx_mem("t1");

    run_stream("t2", 65, -1, -1, -1, -1);
    check_rx_mem("t2");

    do_reset();
    run_stream("hold", 28, 12, -1, -1, -1);
    check("hold_w5", rx_mem[5], 8'h3F);

    for (int i = 0; i < 4; i++) begin
      idle_write(wr_tab[i].addr, wr_tab[i].data);
      if (wr_tab[i].applies) w_model[wr_tab[i].addr] = wr_tab[i].data;
    end
    run_stream("tab", 65, -1, -1, -1, -1);
    check_rx_mem("tab");
    check("tab_w2", rx_mem[2], 8'hA5);

    run_stream("midwr", 65, -1, 45, 50, -1);
    check_rx_mem("midwr");

    wr_en = 1'b1; wr_addr = 4'd0; wr_data = 8'h5A;
    w_model[0] = 8'h5A;
    run_stream("samecyc", 65, -1, -1, -1, -1);
    check("samecyc_w0", rx_mem[0], 8'h5A);

    do_reset();
    idle_write(4'd0, 8'h5A);
    w_model[0] = 8'h5A;
    run_stream("rstmid", 14, -1, -1, -1, 13);
    run_stream("fresh", 25, -1, -1, -1, -1);
    check_rx_mem("fresh");
    check("fresh_w0", rx_mem[0], 8'hB7);

    run_gap_stream();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
